note_lane_scroller: RTL and testbench

Parametrised multi-lane note-chart scroller for the rhythm-game datapath. It loads a per-lane note chart, shifts it toward a strike position on each scroll tick, and exposes a WIN-bit display window per lane. It also judges player presses against the strike position, producing per-lane hit/miss pulses, and flags end-of-song. It sits between the chart source/mode FSM and the display driver/score keeper.

---
 rtl/note_lane_scroller.sv | 116 +++++++++++
 tb/tb_note_lane_scroller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/note_lane_scroller.sv
// Multi-lane rhythm-game chart scroller: per-lane shift registers scroll notes
// toward the strike row, judge presses there, and emit hit/miss pulses.

module note_lane #(
  parameter int SONG_LEN = 32,
  parameter int WIN      = 7
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load,
  input  logic                judge,
  input  logic                step,
  input  logic                press,
  input  logic [SONG_LEN-1:0] chart,
  output logic [WIN-1:0]      window,
  output logic                hit_ok,
  output logic                miss
);
  localparam int L = SONG_LEN + WIN;

  logic [L-1:0] sr;
  logic         hit;
  logic [L-1:0] cur;

  assign hit    = judge & press & sr[L-1];
  // a same-cycle hit clears the strike bit before the shift, so it can never also miss
  assign cur    = {sr[L-1] & ~hit, sr[L-2:0]};
  assign window = sr[L-1 -: WIN];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sr     <= '0;
      hit_ok <= 1'b0;
      miss   <= 1'b0;
    end else if (load) begin
      sr     <= {{WIN{1'b0}}, chart};
      hit_ok <= 1'b0;
      miss   <= 1'b0;
    end else begin
      hit_ok <= hit;
      miss   <= step & cur[L-1];
      if (step) sr <= {cur[L-2:0], 1'b0};
      else      sr <= cur;
    end
  end
endmodule

module note_lane_scroller #(
  parameter  int LANES    = 2,
  parameter  int SONG_LEN = 32,
  parameter  int WIN      = 7,
  localparam int CW       = $clog2(SONG_LEN + WIN + 1)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      load,
  input  logic                      run,
  input  logic                      scroll,
  input  logic [LANES*SONG_LEN-1:0] notes,
  input  logic [LANES-1:0]          press,
  output logic [LANES*WIN-1:0]      window,
  output logic [CW-1:0]             remaining,
  output logic                      playing,
  output logic                      done,
  output logic [LANES-1:0]          hit_ok,
  output logic [LANES-1:0]          miss
);
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t state;
  logic   step;

  assign step = playing & run & scroll;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      remaining <= '0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else if (load) begin
      state     <= PLAY;
      remaining <= CW'(SONG_LEN + WIN);
      playing   <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state)
        PLAY: if (run && scroll) begin
          remaining <= remaining - 1'b1;
          // remaining is never 0 in PLAY, so this is the final step
          if (remaining == CW'(1)) begin
            state   <= DONE;
            playing <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    note_lane #(.SONG_LEN(SONG_LEN), .WIN(WIN)) u_lane (
      .clk    (clk),
      .n_rst  (n_rst),
      .load   (load),
      .judge  (playing),
      .step   (step),
      .press  (press[g]),
      .chart  (notes[g*SONG_LEN +: SONG_LEN]),
      .window (window[g*WIN +: WIN]),
      .hit_ok (hit_ok[g]),
      .miss   (miss[g])
    );
  end
endmodule

// File: tb/tb_note_lane_scroller.sv
// Randomized bench for note_lane_scroller against a note-index model
// (chart + consumed flags + scroll count), plus hand-computed spot checks.

module tb_note_lane_scroller;
  localparam int LANES    = 2;
  localparam int SONG_LEN = 32;
  localparam int WIN      = 7;
  localparam int L        = SONG_LEN + WIN;
  localparam int CW       = $clog2(SONG_LEN + WIN + 1);

  logic                      clk = 1'b0;
  logic                      n_rst = 1'b0;
  logic                      load = 1'b0, run = 1'b0, scroll = 1'b0;
  logic [LANES*SONG_LEN-1:0] notes = '0;
  logic [LANES-1:0]          press = '0;
  logic [LANES*WIN-1:0]      window;
  logic [CW-1:0]             remaining;
  logic                      playing, done;
  logic [LANES-1:0]          hit_ok, miss;

  note_lane_scroller #(.LANES(LANES), .SONG_LEN(SONG_LEN), .WIN(WIN)) dut (
    .clk(clk), .n_rst(n_rst), .load(load), .run(run), .scroll(scroll),
    .notes(notes), .press(press), .window(window), .remaining(remaining),
    .playing(playing), .done(done), .hit_ok(hit_ok), .miss(miss)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: a note is identified by its chart index k (k=0 reaches strike first).
  // After s scroll steps, note k sits at row r = WIN + k - s (row 0 = strike).
  logic [SONG_LEN-1:0] mchart [LANES];
  bit                  mcons  [LANES][SONG_LEN];
  int                  ms  = 0;
  int                  mst = 0;            // 0 idle, 1 play, 2 done
  logic [LANES-1:0]    mhit = '0, mmiss = '0;

  function automatic bit note_at(input int i, input int k);
    bit v = 1'b0;
    if (k >= 0 && k < SONG_LEN)
      if (mchart[i][SONG_LEN-1-k] && !mcons[i][k]) v = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    mhit  = '0;
    mmiss = '0;
    if (!n_rst) begin
      mst = 0; ms = 0;
    end else if (load) begin
      mst = 1; ms = 0;
      for (int i = 0; i < LANES; i++) begin
        mchart[i] = notes[i*SONG_LEN +: SONG_LEN];
        for (int k = 0; k < SONG_LEN; k++) mcons[i][k] = 1'b0;
      end
    end else if (mst == 1) begin
      for (int i = 0; i < LANES; i++) begin
        if (note_at(i, ms - WIN)) begin
          if (press[i]) begin
            mcons[i][ms - WIN] = 1'b1;
            mhit[i] = 1'b1;
          end else if (run && scroll) begin
            mmiss[i] = 1'b1;
          end
        end
      end
      if (run && scroll) begin
        ms++;
        if (ms == L) mst = 2;
      end
    end
  end

  function automatic logic [LANES*WIN-1:0] exp_win();
    logic [LANES*WIN-1:0] w = '0;
    if (mst == 1)
      for (int i = 0; i < LANES; i++)
        for (int r = 0; r < WIN; r++)
          w[i*WIN + WIN-1-r] = note_at(i, ms + r - WIN);
    return w;
  endfunction

  always @(negedge clk) begin
    if (en) begin
      chk("window",    64'(window),    64'(exp_win()));
      chk("remaining", 64'(remaining), (mst == 0) ? 64'd0 : 64'(L - ms));
      chk("playing",   64'(playing),   64'(mst == 1));
      chk("done",      64'(done),      64'(mst == 2));
      chk("hit_ok",    64'(hit_ok),    64'(mhit));
      chk("miss",      64'(miss),      64'(mmiss));
    end
  end

  task automatic tick(input logic l, input logic r, input logic s, input logic [LANES-1:0] p);
    load = l; run = r; scroll = s; press = p;
    @(negedge clk);
  endtask

  int mc0, mc1;

  initial begin
    @(negedge clk);
    en = 1'b1;
    chk("reset_window", 64'(window), 64'd0);
    chk("reset_remaining", 64'(remaining), 64'd0);
    chk("reset_playing", 64'(playing), 64'd0);
    n_rst = 1'b1;
    tick(0, 1, 1, 2'b11);   // scroll/press ignored in IDLE
    chk("idle_ignore", 64'(remaining), 64'd0);

    // directed: load and first window
    notes = {32'hAAAAAAAA, 32'hCCCCCCCC};
    tick(1, 1, 0, 0);
    chk("load_remaining", 64'(remaining), 64'd39);
    chk("load_window", 64'(window), 64'd0);
    chk("load_playing", 64'(playing), 64'd1);
    for (int n = 0; n < 7; n++) begin
      tick(0, 1, 1, 0);
      chk("early_miss", 64'(miss), 64'd0);
    end
    chk("win7_lane0", 64'(window[6:0]), 64'h66);
    chk("win7_lane1", 64'(window[13:7]), 64'h55);
    chk("rem_after7", 64'(remaining), 64'd32);
    tick(0, 1, 0, 2'b01);
    chk("press_hit", 64'(hit_ok), 64'h1);
    chk("press_win0", 64'(window[6:0]), 64'h26);
    tick(0, 1, 1, 0);
    chk("scroll8_miss", 64'(miss), 64'h2);
    chk("scroll8_rem", 64'(remaining), 64'd31);
    tick(0, 1, 1, 2'b01);
    chk("same_cyc_hit", 64'(hit_ok), 64'h1);
    chk("same_cyc_miss", 64'(miss), 64'h0);
    chk("same_cyc_win0", 64'(window[6:0]), 64'h19);

    // directed: full song, no presses, with a pause mid-song
    mc0 = 0; mc1 = 0;
    tick(1, 1, 0, 0);
    for (int n = 0; n < L; n++) begin
      if (n == 10) begin
        tick(0, 0, 1, 0);
        chk("pause_rem", 64'(remaining), 64'd29);
      end
      tick(0, 1, 1, 0);
      mc0 += int'(miss[0]);
      mc1 += int'(miss[1]);
    end
    chk("song_miss0", 64'(mc0), 64'd16);
    chk("song_miss1", 64'(mc1), 64'd16);
    chk("song_done", 64'(done), 64'd1);
    chk("song_rem", 64'(remaining), 64'd0);
    for (int n = 0; n < 3; n++) tick(0, 1, 1, 2'b11);
    chk("done_hold", 64'({done, remaining, window, hit_ok, miss}), 64'(1) << (CW + LANES*WIN + 2*LANES));
    tick(1, 1, 0, 0);
    chk("reload_rem", 64'(remaining), 64'd39);
    for (int n = 0; n < 19; n++) tick(0, 1, 1, 0);
    chk("pre_reset_rem", 64'(remaining), 64'd20);
    n_rst = 1'b0;
    tick(0, 1, 1, 2'b11);
    n_rst = 1'b1;
    chk("midrst_win", 64'(window), 64'd0);
    chk("midrst_rem", 64'(remaining), 64'd0);
    chk("midrst_state", 64'({playing, done}), 64'd0);

    // random phase
    notes = {$urandom, $urandom};
    tick(1, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      int sel = $urandom_range(0, 299);
      n_rst = (sel != 0);
      if (sel >= 1 && sel <= 3) notes = {$urandom, $urandom};
      tick(sel >= 1 && sel <= 3, ($urandom % 4) != 0, ($urandom % 2) == 1,
           LANES'($urandom & $urandom));
    end
    n_rst = 1'b1;
    tick(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
